// File: rtl/mips_multicycle_control_if.sv
// Control bus between the multicycle control unit and the MIPS datapath.
//
// Datapath -> control: opcode, funct (IR fields), mem_ready (memory access
// completes this cycle).
// Control -> datapath: PC write enables and PC mux select, memory strobes and
// address select, IR write, register-file write controls, ULA operand selects
// and the 4-bit ULA operation code.
//
// master: the control unit.  slave: the datapath.
interface mips_multicycle_control_if;
  logic [5:0] opcode;
  logic [5:0] funct;
  logic       mem_ready;

  logic       pc_write;
  logic       pc_write_cond;
  logic [1:0] pc_source;
  logic       i_or_d;
  logic       mem_read;
  logic       mem_write;
  logic       ir_write;
  logic       reg_dst;
  logic       mem_to_reg;
  logic       reg_write;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic [3:0] ula_op;

  modport master (
    input  opcode, funct, mem_ready,
    output pc_write, pc_write_cond, pc_source, i_or_d, mem_read, mem_write,
           ir_write, reg_dst, mem_to_reg, reg_write, alu_src_a, alu_src_b,
           ula_op
  );

  modport slave (
    output opcode, funct, mem_ready,
    input  pc_write, pc_write_cond, pc_source, i_or_d, mem_read, mem_write,
           ir_write, reg_dst, mem_to_reg, reg_write, alu_src_a, alu_src_b,
           ula_op
  );
endinterface

// File: rtl/mips_multicycle_control.sv
// Multicycle MIPS control unit: a Moore FSM that sequences one instruction
// over 3-5 clocks (plus memory wait cycles) through a shared ULA and a shared
// memory, and drives every datapath enable and mux select.
//
// Ports:
//   clock        rising-edge clock
//   reset        asynchronous, active-low; forces FETCH and zeroes all strobes
//   bus          control bus (master side): opcode/funct/mem_ready in,
//                datapath controls out
//   state        current FSM state encoding (debug)
//   illegal      one-cycle pulse in DECODE on an undecodable instruction
//   instr_count  retired-instruction counter, wraps at 2^CNT_W
//
// Handshake: mem_ready is a plain per-cycle completion flag. In FETCH,
// MEM_READ and MEM_WRITE the FSM holds with its strobes asserted until a
// cycle with mem_ready=1; that cycle performs the write/transfer and the FSM
// advances on the following edge. mem_ready is ignored in every other state.
module mips_multicycle_control #(
  parameter int CNT_W = 32
) (
  input  logic                    clock,
  input  logic                    reset,
  mips_multicycle_control_if.master bus,
  output logic [3:0]              state,
  output logic                    illegal,
  output logic [CNT_W-1:0]        instr_count
);

  localparam logic [3:0] S_FETCH     = 4'd0;
  localparam logic [3:0] S_DECODE    = 4'd1;
  localparam logic [3:0] S_MEM_ADDR  = 4'd2;
  localparam logic [3:0] S_MEM_READ  = 4'd3;
  localparam logic [3:0] S_MEM_WB    = 4'd4;
  localparam logic [3:0] S_MEM_WRITE = 4'd5;
  localparam logic [3:0] S_R_EXEC    = 4'd6;
  localparam logic [3:0] S_R_WB      = 4'd7;
  localparam logic [3:0] S_BRANCH    = 4'd8;
  localparam logic [3:0] S_JUMP      = 4'd9;
  localparam logic [3:0] S_ADDI_EXEC = 4'd10;
  localparam logic [3:0] S_ADDI_WB   = 4'd11;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  localparam logic [3:0] ULA_AND = 4'b0000;
  localparam logic [3:0] ULA_OR  = 4'b0001;
  localparam logic [3:0] ULA_ADD = 4'b0010;
  localparam logic [3:0] ULA_SUB = 4'b0110;
  localparam logic [3:0] ULA_SLT = 4'b0111;

  logic [3:0] next_state;
  logic       funct_legal;
  logic       decode_legal;
  logic       retire;

  // Locally built control word, gated by reset before reaching the bus.
  logic       pc_write_d, pc_write_cond_d, i_or_d_d, mem_read_d, mem_write_d;
  logic       ir_write_d, reg_dst_d, mem_to_reg_d, reg_write_d, alu_src_a_d;
  logic [1:0] pc_source_d, alu_src_b_d;
  logic [3:0] ula_op_d;

  always_comb begin
    funct_legal = 1'b0;
    case (bus.funct)
      FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT: funct_legal = 1'b1;
      default:                               funct_legal = 1'b0;
    endcase
  end

  always_comb begin
    decode_legal = 1'b0;
    case (bus.opcode)
      OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J: decode_legal = 1'b1;
      OP_RTYPE:                            decode_legal = funct_legal;
      default:                             decode_legal = 1'b0;
    endcase
  end

  // Next-state logic
  always_comb begin
    next_state = S_FETCH;
    case (state)
      S_FETCH:     next_state = bus.mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (bus.opcode)
          OP_LW, OP_SW: next_state = S_MEM_ADDR;
          OP_RTYPE:     next_state = funct_legal ? S_R_EXEC : S_FETCH;
          OP_BEQ:       next_state = S_BRANCH;
          OP_ADDI:      next_state = S_ADDI_EXEC;
          OP_J:         next_state = S_JUMP;
          default:      next_state = S_FETCH;
        endcase
      end
      S_MEM_ADDR:  next_state = (bus.opcode == OP_SW) ? S_MEM_WRITE : S_MEM_READ;
      S_MEM_READ:  next_state = bus.mem_ready ? S_MEM_WB : S_MEM_READ;
      S_MEM_WB:    next_state = S_FETCH;
      S_MEM_WRITE: next_state = bus.mem_ready ? S_FETCH : S_MEM_WRITE;
      S_R_EXEC:    next_state = S_R_WB;
      S_R_WB:      next_state = S_FETCH;
      S_BRANCH:    next_state = S_FETCH;
      S_JUMP:      next_state = S_FETCH;
      S_ADDI_EXEC: next_state = S_ADDI_WB;
      S_ADDI_WB:   next_state = S_FETCH;
      default:     next_state = S_FETCH;  // codes 12-15 recover
    endcase
  end

  // An instruction retires on the edge that leaves its final state.
  always_comb begin
    retire = 1'b0;
    case (state)
      S_MEM_WB, S_R_WB, S_BRANCH, S_JUMP, S_ADDI_WB: retire = 1'b1;
      S_MEM_WRITE:                                   retire = bus.mem_ready;
      default:                                       retire = 1'b0;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state       <= S_FETCH;
      instr_count <= '0;
    end else begin
      state <= next_state;
      if (retire) instr_count <= instr_count + CNT_W'(1);
    end
  end

  // Output decode
  always_comb begin
    pc_write_d      = 1'b0;
    pc_write_cond_d = 1'b0;
    pc_source_d     = 2'b00;
    i_or_d_d        = 1'b0;
    mem_read_d      = 1'b0;
    mem_write_d     = 1'b0;
    ir_write_d      = 1'b0;
    reg_dst_d       = 1'b0;
    mem_to_reg_d    = 1'b0;
    reg_write_d     = 1'b0;
    alu_src_a_d     = 1'b0;
    alu_src_b_d     = 2'b00;
    ula_op_d        = ULA_ADD;
    case (state)
      S_FETCH: begin
        // PC+4 is computed every FETCH cycle; IR and PC load only on ready.
        mem_read_d  = 1'b1;
        alu_src_b_d = 2'b01;
        ir_write_d  = bus.mem_ready;
        pc_write_d  = bus.mem_ready;
      end
      S_DECODE: begin
        // Speculative branch target (PC + imm<<2) into ALUOut.
        alu_src_b_d = 2'b11;
      end
      S_MEM_ADDR, S_ADDI_EXEC: begin
        alu_src_a_d = 1'b1;
        alu_src_b_d = 2'b10;
      end
      S_MEM_READ: begin
        mem_read_d = 1'b1;
        i_or_d_d   = 1'b1;
      end
      S_MEM_WB: begin
        reg_write_d  = 1'b1;
        mem_to_reg_d = 1'b1;
      end
      S_MEM_WRITE: begin
        mem_write_d = 1'b1;
        i_or_d_d    = 1'b1;
      end
      S_R_EXEC: begin
        alu_src_a_d = 1'b1;
        case (bus.funct)
          FN_SUB:  ula_op_d = ULA_SUB;
          FN_AND:  ula_op_d = ULA_AND;
          FN_OR:   ula_op_d = ULA_OR;
          FN_SLT:  ula_op_d = ULA_SLT;
          default: ula_op_d = ULA_ADD;
        endcase
      end
      S_R_WB: begin
        reg_write_d = 1'b1;
        reg_dst_d   = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a_d     = 1'b1;
        ula_op_d        = ULA_SUB;
        pc_write_cond_d = 1'b1;
        pc_source_d     = 2'b01;
      end
      S_JUMP: begin
        pc_write_d  = 1'b1;
        pc_source_d = 2'b10;
      end
      S_ADDI_WB: begin
        reg_write_d = 1'b1;
      end
      default: ;
    endcase
  end

  // Strobes are gated by reset directly so an asynchronous abort silences
  // them before the next edge; mux selects keep their FETCH values.
  assign bus.pc_write      = reset & pc_write_d;
  assign bus.pc_write_cond = reset & pc_write_cond_d;
  assign bus.ir_write      = reset & ir_write_d;
  assign bus.reg_write     = reset & reg_write_d;
  assign bus.mem_write     = reset & mem_write_d;
  assign bus.mem_read      = reset & mem_read_d;
  assign bus.pc_source     = pc_source_d;
  assign bus.i_or_d        = i_or_d_d;
  assign bus.reg_dst       = reg_dst_d;
  assign bus.mem_to_reg    = mem_to_reg_d;
  assign bus.alu_src_a     = alu_src_a_d;
  assign bus.alu_src_b     = alu_src_b_d;
  assign bus.ula_op        = ula_op_d;
  assign illegal           = reset & (state == S_DECODE) & ~decode_legal;

endmodule

// File: doc/mips_multicycle_control.md
# mips_multicycle_control

Multicycle control unit for the MIPS datapath (PC, instruction memory, register file, ULA, sign extend, PC mux). A Moore FSM sequences one instruction over 3–5 clocks and drives every datapath enable and mux select, including the 4-bit ULA operation code. It stalls on a memory-ready handshake and keeps a retired-instruction counter. It replaces the per-instruction single-cycle wiring with a shared-ULA, shared-memory schedule.

## Interface
Parameters:
- `CNT_W`, default 32, width of the retired-instruction counter.

Ports:
- `clock`  in  1  sole clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-low. 0 forces reset state immediately; release is sampled on `clock`.
- `opcode`  in  6  instruction bits [31:26], valid from the IR after FETCH.
- `funct`  in  6  instruction bits [5:0].
- `mem_ready`  in  1  memory access completes this cycle.
- `pc_write`  out  1  unconditional PC load.
- `pc_write_cond`  out  1  PC load qualified by the ULA zero flag in the datapath.
- `pc_source`  out  2  PC mux select: 00 = ULA result, 01 = ALUOut register, 10 = jump target.
- `i_or_d`  out  1  memory address select: 0 = PC, 1 = ALUOut.
- `mem_read`, `mem_write`, `ir_write`  out  1 each  memory and IR strobes.
- `reg_dst`  out  1  write register select: 0 = rt, 1 = rd.
- `mem_to_reg`  out  1  write data select: 0 = ALUOut, 1 = MDR.
- `reg_write`  out  1  register-file write enable.
- `alu_src_a`  out  1  ULA In1 select: 0 = PC, 1 = reg A.
- `alu_src_b`  out  2  ULA In2 select: 00 = reg B, 01 = constant 4, 10 = sign-extended immediate, 11 = sign-extended immediate << 2.
- `ula_op`  out  4  ULA operation code: 0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0111 SLT.
- `state`  out  4  current state encoding, for debug.
- `illegal`  out  1  one-cycle pulse on an undecodable instruction.
- `instr_count`  out  CNT_W  count of retired instructions.

## Operation
State encodings:

| Code | State |
|---|---|
| 0 | FETCH |
| 1 | DECODE |
| 2 | MEM_ADDR |
| 3 | MEM_READ |
| 4 | MEM_WB |
| 5 | MEM_WRITE |
| 6 | R_EXEC |
| 7 | R_WB |
| 8 | BRANCH |
| 9 | JUMP |
| 10 | ADDI_EXEC |
| 11 | ADDI_WB |

Unused codes 12–15 go to FETCH on the next edge.

- FETCH
  - Drives `mem_read`=1, `i_or_d`=0, `alu_src_a`=0, `alu_src_b`=01, `ula_op`=ADD, `pc_source`=00.
  - `ir_write`=`pc_write`=`mem_ready`.
  - Stays in FETCH while `mem_ready`=0; goes to DECODE when it is 1.
- DECODE
  - Drives `alu_src_a`=0, `alu_src_b`=11, `ula_op`=ADD (branch target into ALUOut).
  - Next state by opcode:
    - 100011 (lw) or 101011 (sw) → MEM_ADDR
    - 000000 with a legal funct → R_EXEC
    - 000100 (beq) → BRANCH
    - 001000 (addi) → ADDI_EXEC
    - 000010 (j) → JUMP
    - anything else → FETCH, with `illegal`=1 for this cycle
- MEM_ADDR: `alu_src_a`=1, `alu_src_b`=10, ADD. Goes to MEM_READ for lw, MEM_WRITE for sw.
- MEM_READ: `mem_read`=1, `i_or_d`=1. Holds until `mem_ready`, then goes to MEM_WB.
- MEM_WB: `reg_write`=1, `reg_dst`=0, `mem_to_reg`=1. Goes to FETCH.
- MEM_WRITE: `mem_write`=1, `i_or_d`=1. Holds until `mem_ready`, then goes to FETCH.
- R_EXEC: `alu_src_a`=1, `alu_src_b`=00. `ula_op` from funct: 100000 ADD, 100010 SUB, 100100 AND, 100101 OR, 101010 SLT. Any other funct is illegal at DECODE. Goes to R_WB.
- R_WB: `reg_write`=1, `reg_dst`=1, `mem_to_reg`=0. Goes to FETCH.
- BRANCH: `alu_src_a`=1, `alu_src_b`=00, SUB, `pc_write_cond`=1, `pc_source`=01. Goes to FETCH.
- JUMP: `pc_write`=1, `pc_source`=10. Goes to FETCH.
- ADDI_EXEC: `alu_src_a`=1, `alu_src_b`=10, ADD. Goes to ADDI_WB.
- ADDI_WB: `reg_write`=1, `reg_dst`=0, `mem_to_reg`=0. Goes to FETCH.
- Default levels: any output not listed for a state is 0, and `ula_op` defaults to ADD.
- Output registering: all outputs are decoded from `state` only (Moore), except the `mem_ready`-qualified strobes and the funct-decoded `ula_op` in R_EXEC.
- `instr_count` increments by 1 on every edge that leaves MEM_WB, MEM_WRITE (with `mem_ready`), R_WB, BRANCH, JUMP or ADDI_WB. It wraps from 2^CNT_W−1 to 0. An illegal instruction does not count.

## Timing
- Reset values (`reset`=0):
  - `state`=FETCH and `instr_count`=0.
  - All write strobes (`pc_write`, `pc_write_cond`, `ir_write`, `reg_write`, `mem_write`) and `mem_read`, `illegal` are forced to 0, overriding the FETCH decode.
- Reset release: the first FETCH cycle is the first clock with `reset`=1.
- Latency in clocks with `mem_ready` held at 1:

| Instruction | Clocks |
|---|---|
| lw | 5 |
| sw | 4 |
| R-type | 4 |
| addi | 4 |
| beq | 3 |
| j | 3 |
| illegal | 2 |

- Each cycle of `mem_ready`=0 in FETCH, MEM_READ or MEM_WRITE adds one clock. Strobes stay asserted (`mem_read`/`mem_write`) but no writes occur until the ready cycle.
- Reset asserted mid-instruction: the FSM aborts immediately and no further `reg_write`/`pc_write` is issued. A write already clocked stays committed.
- `mem_ready` arriving in any state other than FETCH, MEM_READ or MEM_WRITE is ignored.
- Counter wrap and retirement on the same edge: the count wraps to 0 with no other side effect.

## Test plan
- Reset low, then released; `mem_ready`=1, opcode=000000, funct=100000 → states 0,1,6,7,0. `ula_op`=0010 in R_EXEC. `reg_write`=1 with `reg_dst`=1 only in R_WB. `instr_count`=1.
- lw (100011) with `mem_ready` low for 2 cycles in MEM_READ → 7 clocks total. `mem_read`=`i_or_d`=1 held over the 3 MEM_READ cycles. `reg_write`=1 with `mem_to_reg`=1 for exactly one cycle.
- beq (000100) → 3 clocks. In BRANCH: `pc_write_cond`=1, `pc_source`=01, `ula_op`=0110. No `reg_write` at any point.
- Opcode 111111, then funct 000001 with opcode 0 → each gives `illegal`=1 for one cycle in DECODE and returns to FETCH; `instr_count` unchanged.
- Assert `reset`=0 asynchronously mid-R_EXEC → `state`=0 and all strobes 0 before the next edge. The R_WB write never occurs.
- With CNT_W=4, retire 16 j instructions (000010) → `instr_count` reads 15, then 0. `pc_write`=1 with `pc_source`=10 in each JUMP state.
